print_clear_seq: RTL and testbench
==================================

PRINT_CLEAR_SEQ -- requirements
Module: print_clear_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of the pulse, holdoff and timeout counters and registers.
REQ-002 SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port address  input  2  Avalon-MM register select.
REQ-005 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-006 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-007 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-008 SHALL have port readdata  output  32  Avalon-MM read data, combinational from address, zero-extended.
REQ-009 SHALL have port hw_req  input  1  hardware clear request (front-panel, pre-synchronised); rising edge only.
REQ-010 SHALL have port printer_ready  input  1  printer ready, pre-synchronised.
REQ-011 SHALL have port print_clear  output  1  registered clear pulse to printer.
REQ-012 SHALL have port irq  output  1  level interrupt = done & irq_en.

Function
REQ-013 SHALL implement registers: 0 CTRL/STATUS, 1 PULSE_W, 2 HOLDOFF, 3 TIMEOUT; writes occur when chipselect & ~write_n.
REQ-014 CTRL write SHALL decode: bit0 start (write-one), bit1 clear done and err (write-one), bit2 irq_en (stored).
REQ-015 STATUS read SHALL return bit0 busy, bit1 done, bit2 irq_en, bit3 err, bit4 pending, other bits 0.
REQ-016 Registers 1-3 SHALL store writedata[CNT_W-1:0] and read back zero-extended.
REQ-017 A request SHALL be a CTRL start write or a hw_req 0->1 edge; simultaneous sources in one cycle SHALL count as one request.
REQ-018 A request SHALL set pending; further requests while pending is set SHALL be dropped.
REQ-019 FSM states SHALL be IDLE, WAIT_RDY, PULSE, HOLDOFF; busy = state != IDLE.
REQ-020 IDLE with pending SHALL clear pending, load counter, go WAIT_RDY next cycle.
REQ-021 WAIT_RDY with printer_ready=1 SHALL go PULSE next cycle; print_clear SHALL be 1 exactly during PULSE.
REQ-022 WAIT_RDY SHALL count cycles; at count == TIMEOUT (TIMEOUT != 0) SHALL set err, skip pulse, go IDLE; TIMEOUT == 0 SHALL wait indefinitely.
REQ-023 PULSE SHALL last max(PULSE_W,1) cycles, then go HOLDOFF.
REQ-024 HOLDOFF SHALL last HOLDOFF cycles, then go IDLE setting done; HOLDOFF == 0 SHALL go IDLE directly after PULSE setting done.
REQ-025 Request latency SHALL be: start write in cycle N -> pending in N+1 -> WAIT_RDY in N+2 -> print_clear high in N+3 if printer_ready high.
REQ-026 Register writes during a sequence SHALL take effect on the next sequence only (values latched at WAIT_RDY entry).
REQ-027 done/err clear coincident with done/err set SHALL leave the flag set.
REQ-028 Counters SHALL saturate, never wrap.

Reset
REQ-029 reset_n low SHALL force IDLE, print_clear 0, irq 0, pending/done/err/irq_en 0, PULSE_W 100, HOLDOFF 1000, TIMEOUT all-ones, hw_req edge history 0.
REQ-030 Reset mid-sequence SHALL drop print_clear within the same reset assertion, with no further pulse after release.

Structure
REQ-031 Shared package SHALL hold register addresses, CTRL/STATUS bit positions, FSM state encoding, and reset values.
REQ-032 One sub-module, pcs_down_counter (loadable, saturating-at-zero, CNT_W wide), SHALL be shared by WAIT_RDY, PULSE and HOLDOFF.

Verification
REQ-033 PULSE_W=3, HOLDOFF=2, ready=1, start at N -> print_clear high N+3..N+5, done=1 at N+8, irq=1 if irq_en.
REQ-034 ready=0, TIMEOUT=5, start -> no pulse, err=1, busy=0 after 5 WAIT_RDY cycles; CTRL bit1 write clears err.
REQ-035 start and hw_req edge same cycle, then start during PULSE -> exactly two pulses, third request while pending dropped.
REQ-036 PULSE_W=0, HOLDOFF=0 -> one-cycle pulse, IDLE next cycle, done set.
REQ-037 reset_n low during PULSE -> print_clear 0 immediately, registers at reset values, no pulse after release.

Source files
------------

// File: rtl/print_clear_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : print_clear_seq_pkg
// Description : Shared definitions for the printer clear sequencer: register
//               map, CTRL/STATUS bit positions, FSM encoding, reset values.
// Revision    : 1.0 - initial release
// ============================================================================
package print_clear_seq_pkg;

    // Register map
    localparam logic [1:0] C_ADDR_CTRL    = 2'd0;
    localparam logic [1:0] C_ADDR_PULSE_W = 2'd1;
    localparam logic [1:0] C_ADDR_HOLDOFF = 2'd2;
    localparam logic [1:0] C_ADDR_TIMEOUT = 2'd3;

    // CTRL write bits
    localparam int C_CTRL_START_BIT  = 0;
    localparam int C_CTRL_CLEAR_BIT  = 1;
    localparam int C_CTRL_IRQ_EN_BIT = 2;

    // STATUS read bits
    localparam int C_STAT_BUSY_BIT    = 0;
    localparam int C_STAT_DONE_BIT    = 1;
    localparam int C_STAT_IRQ_EN_BIT  = 2;
    localparam int C_STAT_ERR_BIT     = 3;
    localparam int C_STAT_PENDING_BIT = 4;

    // Reset values of the timing registers (TIMEOUT resets to all-ones)
    localparam int C_RST_PULSE_W = 100;
    localparam int C_RST_HOLDOFF = 1000;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_PULSE    = 2'd2,
        ST_HOLDOFF  = 2'd3
    } pcs_state_e;

endpackage : print_clear_seq_pkg
`default_nettype wire

// File: rtl/pcs_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : pcs_down_counter
// Description : Loadable down counter that saturates at zero. Shared by the
//               WAIT_RDY, PULSE and HOLDOFF phases of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module pcs_down_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Load has priority; decrement stops at zero instead of wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule : pcs_down_counter
`default_nettype wire

// File: rtl/print_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : print_clear_seq
// Description : Avalon-MM controlled printer clear sequencer. A start write
//               or a hw_req rising edge queues one request; the FSM waits
//               for printer_ready (with optional timeout), drives a clear
//               pulse, then observes a holdoff before flagging done.
// Revision    : 1.0 - initial release
// ============================================================================
module print_clear_seq
    import print_clear_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        hw_req,
    input  logic        printer_ready,
    output logic        print_clear,
    output logic        irq
);

    pcs_state_e       r_state;
    pcs_state_e       w_next;
    logic [CNT_W-1:0] r_pulse_w, r_holdoff, r_timeout;
    logic [CNT_W-1:0] r_sh_pulse_w, r_sh_holdoff;
    logic             r_sh_to_en;
    logic             r_irq_en, r_done, r_err, r_pending, r_hw_q, r_print_clear;
    logic             w_wr, w_ctrl_wr, w_start, w_clr, w_req;
    logic             w_seq_start, w_set_done, w_set_err;
    logic             w_cnt_load, w_cnt_dec;
    logic [CNT_W-1:0] w_cnt_val, w_count, w_pulse_len;
    logic             w_unused_ok;

    assign w_wr      = chipselect & ~write_n;
    assign w_ctrl_wr = w_wr && (address == C_ADDR_CTRL);
    assign w_start   = w_ctrl_wr & writedata[C_CTRL_START_BIT];
    assign w_clr     = w_ctrl_wr & writedata[C_CTRL_CLEAR_BIT];
    // Both sources in one cycle merge into a single request
    assign w_req     = w_start | (hw_req & ~r_hw_q);
    // A zero pulse width still produces a one-cycle pulse
    assign w_pulse_len = (r_sh_pulse_w == '0) ? CNT_W'(1) : r_sh_pulse_w;
    assign w_unused_ok = &{1'b0, writedata};

    pcs_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_count    (w_count)
    );

    // Software-visible configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pulse_w <= CNT_W'(C_RST_PULSE_W);
            r_holdoff <= CNT_W'(C_RST_HOLDOFF);
            r_timeout <= '1;
            r_irq_en  <= 1'b0;
        end else if (w_wr) begin
            case (address)
                C_ADDR_CTRL:    r_irq_en  <= writedata[C_CTRL_IRQ_EN_BIT];
                C_ADDR_PULSE_W: r_pulse_w <= writedata[CNT_W-1:0];
                C_ADDR_HOLDOFF: r_holdoff <= writedata[CNT_W-1:0];
                default:        r_timeout <= writedata[CNT_W-1:0];
            endcase
        end
    end

    // Snapshot of timing values so mid-sequence writes only affect the next run
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_pulse_w <= '0;
            r_sh_holdoff <= '0;
            r_sh_to_en   <= 1'b0;
        end else if (w_seq_start) begin
            r_sh_pulse_w <= r_pulse_w;
            r_sh_holdoff <= r_holdoff;
            r_sh_to_en   <= (r_timeout != '0);
        end
    end

    // Request queueing and sticky status flags; a set wins over a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_hw_q    <= 1'b0;
        end else begin
            r_hw_q <= hw_req;
            if (w_seq_start) begin
                r_pending <= 1'b0;
            end else if (w_req) begin
                r_pending <= 1'b1;
            end
            if (w_set_done) begin
                r_done <= 1'b1;
            end else if (w_clr) begin
                r_done <= 1'b0;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end else if (w_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // State register and registered clear pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_print_clear <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_print_clear <= (w_next == ST_PULSE);
        end
    end

    // Next-state logic and counter control; the shared counter is reloaded on
    // every phase change and each phase ends when it reads one
    always_comb begin
        w_next      = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;
        w_seq_start = 1'b0;
        w_set_done  = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    w_seq_start = 1'b1;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = r_timeout;
                    w_next      = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (printer_ready) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = w_pulse_len;
                    w_next     = ST_PULSE;
                end else if (r_sh_to_en && (w_count == CNT_W'(1))) begin
                    w_set_err = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (w_count == CNT_W'(1)) begin
                    if (r_sh_holdoff == '0) begin
                        w_set_done = 1'b1;
                        w_next     = ST_IDLE;
                    end else begin
                        w_cnt_load = 1'b1;
                        w_cnt_val  = r_sh_holdoff;
                        w_next     = ST_HOLDOFF;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (w_count == CNT_W'(1)) begin
                    w_set_done = 1'b1;
                    w_next     = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_cnt_dec = (r_state != ST_IDLE) && !w_cnt_load;

    // Combinational read mux, zero-extended
    always_comb begin
        readdata = '0;
        case (address)
            C_ADDR_CTRL: begin
                readdata[C_STAT_BUSY_BIT]    = (r_state != ST_IDLE);
                readdata[C_STAT_DONE_BIT]    = r_done;
                readdata[C_STAT_IRQ_EN_BIT]  = r_irq_en;
                readdata[C_STAT_ERR_BIT]     = r_err;
                readdata[C_STAT_PENDING_BIT] = r_pending;
            end
            C_ADDR_PULSE_W: readdata = 32'(r_pulse_w);
            C_ADDR_HOLDOFF: readdata = 32'(r_holdoff);
            default:        readdata = 32'(r_timeout);
        endcase
    end

    assign print_clear = r_print_clear;
    assign irq         = r_done & r_irq_en;

endmodule : print_clear_seq
`default_nettype wire

// File: tb/tb_print_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_print_clear_seq
// Description : Scoreboard bench for print_clear_seq. Stimulus pushes the
//               expected pulse (start cycle, width) into a queue; a monitor
//               pops and compares on each observed print_clear pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_print_clear_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic        hw_req = 1'b0;
    logic        printer_ready = 1'b1;
    logic [31:0] readdata;
    logic        print_clear;
    logic        irq;

    typedef struct {
        int rise;
        int width;
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t mon_e;
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     npulses = 0;
    int     rise_c = 0;
    logic   prev_pc = 1'b0;

    print_clear_seq #(.CNT_W(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .writedata     (writedata),
        .readdata      (readdata),
        .hw_req        (hw_req),
        .printer_ready (printer_ready),
        .print_clear   (print_clear),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    // Cycle index = number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=expired required=event", name);
    endtask

    // Monitor: every completed print_clear pulse is matched to the scoreboard
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            prev_pc = 1'b0;
        end else begin
            if (print_clear && !prev_pc) begin
                rise_c = cyc;
                npulses++;
            end
            if (!print_clear && prev_pc) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: actual rise=%0d required=none", rise_c);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_rise", rise_c, mon_e.rise);
                    check("pulse_width", cyc - rise_c, mon_e.width);
                end
            end
            prev_pc = print_clear;
        end
    end

    // Single write; p = index of the rising edge that samples it
    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int p);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        p = cyc + 1;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        #1 d = readdata;
        address = 2'd0;
    endtask

    task automatic wait_done(output int c, output bit ok);
        ok = 0; c = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (readdata[1]) begin
                c = cyc; ok = 1;
                return;
            end
        end
    endtask

    task automatic wait_pc(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (print_clear) begin
                ok = 1;
                return;
            end
        end
    endtask

    // One full sequence with printer ready; expectations come from the rules:
    // pulse starts 2 edges after the start write, lasts max(pw,1), done after holdoff
    task automatic run_seq(input int pw, input int h, input bit ien);
        int p, c, w, d;
        bit ok;
        logic [31:0] s;
        wr(2'd1, pw, d);
        wr(2'd2, h, d);
        wr(2'd3, 0, d);
        wr(2'd0, 32'h1 | (32'(ien) << 2), p);
        w = (pw == 0) ? 1 : pw;
        exp_q.push_back('{rise: p + 2, width: w});
        wait_done(c, ok);
        if (!ok) fail_now("done_wait");
        else begin
            check("done_cycle", c, p + 2 + w + h);
            check("irq_level", irq, ien);
            check("busy_after_done", readdata[0], 0);
        end
        wr(2'd0, 32'h2 | (32'(ien) << 2), d);
        rd(2'd0, s);
        check("done_cleared", s[1], 0);
    endtask

    initial begin
        int p, c, d, n0, pw, h;
        bit ok, ien;
        logic [31:0] s;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_print_clear", print_clear, 0);
        check("rst_irq", irq, 0);
        reset_n = 1'b1;
        rd(2'd0, s); check("rst_status", s, 0);
        rd(2'd1, s); check("rst_pulse_w", s, 100);
        rd(2'd2, s); check("rst_holdoff", s, 1000);
        rd(2'd3, s); check("rst_timeout", s, 32'h0000_FFFF);

        // Basic sequence and one-cycle degenerate case
        run_seq(3, 2, 1'b1);
        run_seq(0, 0, 1'b0);

        // Randomized sequences
        for (int i = 0; i < 6; i++) begin
            pw  = $urandom_range(0, 6);
            h   = $urandom_range(0, 5);
            ien = 1'($urandom_range(0, 1));
            run_seq(pw, h, ien);
        end

        // Timeout with printer not ready: no pulse, err after 5 waiting cycles
        printer_ready = 1'b0;
        wr(2'd0, 32'h0, d);
        wr(2'd3, 5, d);
        wr(2'd0, 32'h1, p);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (readdata[3]) begin ok = 1; c = cyc; break; end
        end
        if (!ok) fail_now("err_wait");
        else begin
            check("timeout_cycle", c, p + 6);
            check("timeout_status", readdata, 32'h8);
        end
        wr(2'd0, 32'h2, d);
        rd(2'd0, s); check("err_cleared", s, 0);
        printer_ready = 1'b1;
        wr(2'd3, 0, d);

        // Merged start+hw_req, second request during pulse, third dropped
        wr(2'd1, 2, d);
        wr(2'd2, 1, d);
        n0 = npulses;
        @(negedge clk);
        address = 2'd0; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0; hw_req = 1'b1;
        p = cyc + 1;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        exp_q.push_back('{rise: p + 2, width: 2});
        exp_q.push_back('{rise: p + 7, width: 2});
        wait_pc(ok);
        if (!ok) fail_now("pulse_wait");
        wr(2'd0, 32'h1, d);
        wr(2'd0, 32'h1, d);
        hw_req = 1'b0;
        repeat (40) @(negedge clk);
        check("two_pulses", npulses - n0, 2);
        check("queue_drained", exp_q.size(), 0);
        wr(2'd0, 32'h2, d);

        // Mid-sequence register write only affects the next sequence
        wr(2'd1, 4, d);
        wr(2'd2, 1, d);
        wr(2'd0, 32'h1, p);
        wr(2'd1, 1, d);
        exp_q.push_back('{rise: p + 2, width: 4});
        wait_done(c, ok);
        if (!ok) fail_now("done_wait2");
        else check("latched_done_cycle", c, p + 7);
        wr(2'd0, 32'h2, d);
        wr(2'd0, 32'h1, p);
        exp_q.push_back('{rise: p + 2, width: 1});
        wait_done(c, ok);
        if (!ok) fail_now("done_wait3");
        else check("next_seq_done_cycle", c, p + 4);
        wr(2'd0, 32'h2, d);

        // Reset asserted during a pulse
        wr(2'd1, 10, d);
        wr(2'd2, 3, d);
        wr(2'd0, 32'h5, p);
        exp_q.push_back('{rise: p + 2, width: 10});
        wait_pc(ok);
        if (!ok) fail_now("pulse_wait2");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_print_clear", print_clear, 0);
        check("rst_mid_irq", irq, 0);
        rd(2'd0, s); check("rst_mid_status", s, 0);
        rd(2'd1, s); check("rst_mid_pulse_w", s, 100);
        rd(2'd2, s); check("rst_mid_holdoff", s, 1000);
        rd(2'd3, s); check("rst_mid_timeout", s, 32'h0000_FFFF);
        @(negedge clk);
        reset_n = 1'b1;
        n0 = npulses;
        repeat (40) @(negedge clk);
        check("no_pulse_after_reset", npulses - n0, 0);
        check("status_after_reset", readdata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=expired required=finish");
        $fatal(1, "bench timeout");
    end

endmodule : tb_print_clear_seq
`default_nettype wire
